// File: rtl/iecdrv_sd_arbiter_pkg.sv
// Shared types and constants for the IEC drive SD-channel arbiter.
package iecdrv_pkg;

  localparam int SD_LBA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } sdarb_state_t;

  // Next requester index after idx, wrapping to 0 at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/iecdrv_sd_arbiter_if.sv
// Host-side MiSTer SD block-device channel as seen by the arbiter.
// master: the arbiter (issues sector requests); slave: the host.
interface iecdrv_sd_arbiter_if;
  import iecdrv_pkg::*;

  logic [SD_LBA_W-1:0] sd_lba;
  logic                sd_rd;
  logic                sd_wr;
  logic                sd_ack;
  logic                sd_buff_wr;
  logic [7:0]          sd_buff_din;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_wr
  );

endinterface

// File: rtl/iecdrv_sd_arbiter_rr_pick.sv
// Round-robin priority encoder: first pending requester at or after rr_ptr,
// wrapping modulo NDR. Purely combinational.
module iecdrv_rr_pick #(
  parameter int NDR = 4,
  parameter int IDW = 2
) (
  input  logic [NDR-1:0] pend,
  input  logic [IDW-1:0] rr_ptr,
  output logic [IDW-1:0] grant,
  output logic           any
);

  logic [IDW-1:0] idx;

  // Scan downward from the farthest candidate so the closest one to rr_ptr wins last.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = NDR - 1; k >= 0; k--) begin
      idx = IDW'((int'(rr_ptr) + k) % NDR);
      if (pend[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iecdrv_sd_arbiter.sv
// Shares one SD block-device channel between NDR IEC drives.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner; grant next pending drive once host ack is low
// REQ     | sd_rd/sd_wr raised for the owner, waiting for host ack
// XFER    | host transferring; ack and buffer strobes routed to owner
// RELEASE | one quiet cycle so the owner can drop its request level
module iecdrv_sd_arbiter
  import iecdrv_pkg::*;
#(
  parameter int NDR = 4,
  parameter int IDW = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SD_LBA_W*NDR-1:0] req_lba,
  input  logic [NDR-1:0]          req_rd,
  input  logic [NDR-1:0]          req_wr,
  output logic [NDR-1:0]          req_ack,
  output logic [NDR-1:0]          req_buff_wr,
  input  logic [8*NDR-1:0]        req_buff_din,
  iecdrv_sd_arbiter_if.master     sd,
  output logic [IDW-1:0]          owner,
  output logic                    busy
);

  sdarb_state_t state, state_nxt;

  logic [NDR-1:0]      pend;
  logic [IDW-1:0]      pick;
  logic                pick_any;
  logic [SD_LBA_W-1:0] pick_lba;
  logic                pick_wr;

  logic [IDW-1:0]      owner_q;
  logic [IDW-1:0]      rr_ptr;
  logic [SD_LBA_W-1:0] lba_q;
  logic                op_wr;
  logic                rd_q;
  logic                wr_q;
  logic [7:0]          buff_din;

  logic                grant;
  logic                host_took;
  logic                done;

  assign pend = req_rd | req_wr;

  iecdrv_rr_pick #(
    .NDR (NDR),
    .IDW (IDW)
  ) u_pick (
    .pend   (pend),
    .rr_ptr (rr_ptr),
    .grant  (pick),
    .any    (pick_any)
  );

  // Select LBA and direction of the candidate; write wins when both levels are high.
  always_comb begin
    pick_lba = '0;
    pick_wr  = 1'b0;
    for (int i = 0; i < NDR; i++) begin
      if (pick == IDW'(i)) begin
        pick_lba = req_lba[SD_LBA_W*i +: SD_LBA_W];
        pick_wr  = req_wr[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a stale host ack in IDLE holds off any grant.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    host_took = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any && !sd.sd_ack) begin
          grant     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (sd.sd_ack) begin
          host_took = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (!sd.sd_ack) state_nxt = RELEASE;
      end
      RELEASE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the granted request; it stays committed even if the drive drops its level.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= '0;
      rr_ptr  <= '0;
      lba_q   <= '0;
      op_wr   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      if (grant) begin
        owner_q <= pick;
        lba_q   <= pick_lba;
        op_wr   <= pick_wr;
        rd_q    <= ~pick_wr;
        wr_q    <= pick_wr;
      end else if (host_took) begin
        rd_q <= 1'b0;
        wr_q <= 1'b0;
      end
      if (done) begin
        rr_ptr <= IDW'(rr_next({{(32-IDW){1'b0}}, owner_q}, NDR));
      end
    end
  end

  // Route ack and strobes to the owner during XFER only; data mux always follows owner.
  always_comb begin
    req_ack     = '0;
    req_buff_wr = '0;
    buff_din    = '0;
    for (int i = 0; i < NDR; i++) begin
      if (owner_q == IDW'(i)) begin
        buff_din = req_buff_din[8*i +: 8];
        if (state == XFER) begin
          req_ack[i]     = sd.sd_ack;
          req_buff_wr[i] = sd.sd_buff_wr;
        end
      end
    end
  end

  assign sd.sd_lba      = lba_q;
  assign sd.sd_rd       = rd_q;
  assign sd.sd_wr       = wr_q;
  assign sd.sd_buff_din = buff_din;
  assign owner          = owner_q;
  assign busy           = (state != IDLE);

endmodule
